multi_dispense_scheduler: RTL and testbench
===========================================

// Module: multi_dispense_scheduler
// PURPOSE
//  Parametrised successor to the per-channel dispenser: schedules doses for NUM_CH pill channels over NUM_SLOTS daily time slots.
//  Queues requests per channel and serialises motor actuation so only one motor fires at a time, round-robin.
//  Drives a sticky patient alarm until acknowledged. Sits between the dispense-time pulse generator/override logic and the motor GPIO, LEDR and alarm.
// PARAMETERS
//  NUM_CH        4    number of dispenser channels (1..8)
//  NUM_SLOTS     3    number of daily dispense slots (1..8)
//  MAX_PEND      3    per-channel pending-dose saturation limit (1..15)
//  PULSE_CYCLES  25   motor-on duration in clock cycles (>=1)
//  GAP_CYCLES    5    mandatory idle cycles between two actuations (>=1)
// PORTS
//  CLOCK_50      in   1                  system clock; all logic on rising edge
//  reset         in   1                  synchronous, active-high
//  slot_p        in   NUM_SLOTS          one-cycle pulse per slot at its dispense time
//  slot_mask     in   NUM_CH*NUM_SLOTS   bit [c*NUM_SLOTS+s]=1: channel c dispenses in slot s
//  override_p    in   NUM_CH             one-cycle manual-override pulse per channel
//  ack_p         in   1                  one-cycle patient acknowledge pulse
//  motor         out  NUM_CH             one-hot motor drive (all-zero when idle)
//  busy          out  1                  high in FIRE or GAP
//  alarm         out  1                  sticky dose-ready alarm
//  dropped       out  NUM_CH             sticky: a request to channel c was lost to saturation
// BEHAVIOUR
//  Reset (sync, active-high): all pending counters=0, motor=0, busy=0, alarm=0, dropped=0, FSM=IDLE, round-robin pointer=0.
//  Request per channel c in cycle t: req_c = override_p[c] | OR_s(slot_p[s] & slot_mask[c*NUM_SLOTS+s]).
//  Multiple requests to one channel in one cycle count as one.
//  Pending counter pend_c, width $clog2(MAX_PEND+1):
//   - inc on req_c, dec when c is granted (FIRE entry).
//   - inc & dec in the same cycle: unchanged.
//   - inc at MAX_PEND without dec: hold at MAX_PEND, set dropped[c].
//  FSM states IDLE, FIRE, GAP:
//   - IDLE: if any pend_c>0, grant the first such c searching from rr_ptr upward with wrap.
//     Next state FIRE; motor[c]=1 from next cycle; pend_c--; rr_ptr=(c+1) mod NUM_CH.
//   - FIRE: motor held one-hot for exactly PULSE_CYCLES cycles, then GAP with motor=0.
//   - GAP: motor=0 for exactly GAP_CYCLES cycles, then IDLE.
//  Latency: req in cycle t -> pend visible t+1 -> motor high t+2 when FSM idle. Same cycle count on the first request after reset.
//  Back-to-back doses: motor low for GAP_CYCLES+1 cycles between pulses (GAP plus one IDLE arbitration cycle).
//  alarm: set on every FIRE entry; cleared by ack_p. ack_p on a FIRE-entry cycle leaves alarm set (set wins).
//  ack_p has no effect on queued or in-progress doses.
//  busy=1 in FIRE and GAP, 0 in IDLE. slot_mask is sampled only when slot_p fires; changes never abort a FIRE.
//  Reset mid-FIRE: motor=0 on the next edge; all queued doses are discarded.
// TESTING
//  1 Reset, slot_p[0] pulse, mask ch0/s0 only -> motor=4'b0001 from t+2 for 25 cycles; alarm=1; pend0 returns to 0.
//  2 slot_p[1] with ch0..ch3 all masked -> motors fire 0,1,2,3 in order, each 25 on, 6 low between, busy continuous.
//  3 override_p[2] x5 during a FIRE on ch0 -> ch2 fires 3 times (MAX_PEND); dropped[2]=1; other bits 0.
//  4 ack_p on the same cycle as FIRE entry -> alarm stays 1; ack_p one cycle later -> alarm=0 while motor still high.
//  5 reset asserted at FIRE cycle 10 with pend1=2 -> next cycle motor=0, busy=0, alarm=0; no further pulses.
//  6 rr fairness: ch3 served, then ch0 and ch3 requested together -> ch0 granted first.

Source files
------------

// File: rtl/multi_dispense_scheduler.sv
// Multi-channel pill dispense scheduler.
// Turns slot and override pulses into per-channel pending-dose counts and fires
// one motor at a time, round-robin, with a fixed pulse length and a fixed gap
// between pulses. Raises a sticky alarm on each dose and flags lost requests.
//
// Handshake: there is no valid/ready flow control here. Every input is a
// one-cycle pulse that is consumed on the clock edge that samples it. A request
// that arrives while its channel already holds MAX_PEND doses is not applied;
// instead dropped[c] is raised and stays high until reset.
module multi_dispense_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int NUM_SLOTS    = 3,
  parameter int MAX_PEND     = 3,
  parameter int PULSE_CYCLES = 25,
  parameter int GAP_CYCLES   = 5
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [NUM_SLOTS-1:0]          slot_p,
  input  logic [NUM_CH*NUM_SLOTS-1:0]   slot_mask,
  input  logic [NUM_CH-1:0]             override_p,
  input  logic                          ack_p,
  output logic [NUM_CH-1:0]             motor,
  output logic                          busy,
  output logic                          alarm,
  output logic [NUM_CH-1:0]             dropped,
  output logic [1:0]                    fsm_state_o
);

  localparam int CW   = $clog2(MAX_PEND + 1);
  localparam int PW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q;
  logic [TW-1:0]       tmr_q;
  logic [PW-1:0]       rr_q;
  logic [NUM_CH-1:0]   motor_q;
  logic                busy_q;
  logic                alarm_q;

  logic [CW-1:0]       pend_q [NUM_CH];
  logic [CW-1:0]       pend_d [NUM_CH];
  logic [NUM_CH-1:0]   dropped_q;
  logic [NUM_CH-1:0]   dropped_d;

  logic [NUM_CH-1:0]   req;
  logic                grant_vld;
  logic [PW-1:0]       grant_idx;
  logic [PW-1:0]       srch_idx;
  logic [NUM_CH-1:0]   grant_oh;
  logic [PW-1:0]       rr_next;

  // Merge slot pulses (through the channel's mask) and manual overrides into
  // one request bit per channel; coincident requests count once.
  always_comb begin
    req = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      req[c] = override_p[c];
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (slot_p[s] && slot_mask[c*NUM_SLOTS+s]) begin
          req[c] = 1'b1;
        end
      end
    end
  end

  // Round-robin search from rr_q upward for the first channel with a pending
  // dose; only acted on while the FSM is idle.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    srch_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      srch_idx = PW'((32'(rr_q) + i) % NUM_CH);
      if (!grant_vld && (pend_q[srch_idx] != '0)) begin
        grant_vld = (state_q == S_IDLE);
        grant_idx = srch_idx;
      end
    end
    grant_oh = '0;
    grant_oh[grant_idx] = 1'b1;
    rr_next = (grant_idx == PW'(NUM_CH - 1)) ? '0 : grant_idx + PW'(1);
  end

  // Pending counters: increment on request, decrement on grant, saturate at
  // MAX_PEND and record the lost request in the sticky dropped flag.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pend_d[c]    = pend_q[c];
      dropped_d[c] = dropped_q[c];
      if (req[c] && !(grant_vld && (grant_idx == PW'(c)))) begin
        if (pend_q[c] == CW'(MAX_PEND)) begin
          dropped_d[c] = 1'b1;
        end else begin
          pend_d[c] = pend_q[c] + CW'(1);
        end
      end else if (!req[c] && grant_vld && (grant_idx == PW'(c))) begin
        pend_d[c] = pend_q[c] - CW'(1);
      end
    end
  end

  // Register pending counters and drop flags.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pend_q[c] <= '0;
      end
      dropped_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        pend_q[c] <= pend_d[c];
      end
      dropped_q <= dropped_d;
    end
  end

  // Actuation FSM: IDLE arbitrates, FIRE holds one motor for PULSE_CYCLES,
  // GAP keeps all motors off for GAP_CYCLES; alarm set on grant beats ack.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      rr_q    <= '0;
      motor_q <= '0;
      busy_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      if (grant_vld) begin
        alarm_q <= 1'b1;
      end else if (ack_p) begin
        alarm_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            state_q <= S_FIRE;
            tmr_q   <= '0;
            motor_q <= grant_oh;
            busy_q  <= 1'b1;
            rr_q    <= rr_next;
          end
        end
        S_FIRE: begin
          if (tmr_q == TW'(PULSE_CYCLES - 1)) begin
            state_q <= S_GAP;
            tmr_q   <= '0;
            motor_q <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_GAP: begin
          if (tmr_q == TW'(GAP_CYCLES - 1)) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tmr_q   <= '0;
          motor_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign motor       = motor_q;
  assign busy        = busy_q;
  assign alarm       = alarm_q;
  assign dropped     = dropped_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_multi_dispense_scheduler.sv
// Bench for multi_dispense_scheduler: directed scenarios plus random traffic,
// checked every cycle against a timeline model of the dispense schedule.
module tb_multi_dispense_scheduler;

  localparam int NC = 4;
  localparam int NS = 3;
  localparam int MP = 3;
  localparam int PC = 25;
  localparam int GC = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [NS-1:0]     slot_p = '0;
  logic [NC*NS-1:0]  slot_mask = '0;
  logic [NC-1:0]     override_p = '0;
  logic              ack_p = 1'b0;
  logic [NC-1:0]     motor;
  logic              busy;
  logic              alarm;
  logic [NC-1:0]     dropped;
  logic [1:0]        fsm_state;

  multi_dispense_scheduler #(
    .NUM_CH(NC), .NUM_SLOTS(NS), .MAX_PEND(MP),
    .PULSE_CYCLES(PC), .GAP_CYCLES(GC)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .slot_p(slot_p), .slot_mask(slot_mask),
    .override_p(override_p), .ack_p(ack_p), .motor(motor), .busy(busy),
    .alarm(alarm), .dropped(dropped), .fsm_state_o(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [NC-1:0] exp_q[$];      // expected motor one-hot per grant, in order
  logic [NC-1:0] prev_motor = '0;

  // Timeline model: pending counts plus the cycle numbers of the current
  // pulse and of the next cycle in which arbitration may happen.
  int            m_cyc = 0;
  int            m_pend[NC];
  int            m_rr = 0;
  int            m_arb = 0;
  int            m_fs = -1000;
  int            m_fch = 0;
  logic          m_alarm = 1'b0;
  logic [NC-1:0] m_drop = '0;
  logic [NC*NS-1:0] mask_r = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, m_cyc, got, exp);
    end
  endtask

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_edge(input logic rst, input logic [NS-1:0] sp,
                            input logic [NC-1:0] ov, input logic ack);
    int  gch;
    logic g;
    logic r;
    logic [NC-1:0] oh;
    if (rst) begin
      for (int c = 0; c < NC; c++) m_pend[c] = 0;
      m_rr = 0; m_arb = m_cyc + 1; m_fs = -1000; m_alarm = 1'b0; m_drop = '0;
      exp_q.delete();
    end else begin
      g = 1'b0; gch = 0;
      if (m_cyc >= m_arb) begin
        for (int k = 0; k < NC; k++) begin
          if (!g && m_pend[(m_rr + k) % NC] > 0) begin
            g = 1'b1; gch = (m_rr + k) % NC;
          end
        end
        if (g) begin
          m_fs = m_cyc + 1; m_fch = gch;
          m_arb = m_cyc + 1 + PC + GC;
          m_rr = (gch + 1) % NC;
          oh = '0; oh[gch] = 1'b1;
          exp_q.push_back(oh);
        end else begin
          m_arb = m_cyc + 1;
        end
      end
      for (int c = 0; c < NC; c++) begin
        r = ov[c];
        for (int s = 0; s < NS; s++) if (sp[s] && mask_r[c*NS+s]) r = 1'b1;
        if (g && gch == c) begin
          if (!r) m_pend[c] = m_pend[c] - 1;
        end else if (r) begin
          if (m_pend[c] == MP) m_drop[c] = 1'b1;
          else m_pend[c] = m_pend[c] + 1;
        end
      end
      if (g) m_alarm = 1'b1;
      else if (ack) m_alarm = 1'b0;
    end
    m_cyc++;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, clock once, then compare at the
  // next falling edge.
  task automatic step(input logic rst, input logic [NS-1:0] sp,
                      input logic [NC-1:0] ov, input logic ack);
    logic [NC-1:0] em;
    logic          eb;
    reset = rst; slot_p = sp; override_p = ov; ack_p = ack; slot_mask = mask_r;
    model_edge(rst, sp, ov, ack);
    @(posedge clk);
    @(negedge clk);
    em = '0;
    if (m_cyc >= m_fs && m_cyc < m_fs + PC) em[m_fch] = 1'b1;
    eb = (m_cyc < m_arb);
    chk("motor", 32'(motor), 32'(em));
    chk("busy", 32'(busy), 32'(eb));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("dropped", 32'(dropped), 32'(m_drop));
    chk("state_busy", 32'(fsm_state != 2'd0), 32'(eb));
    if (prev_motor == '0 && motor != '0) begin
      if (exp_q.size() == 0) chk("grant_unexpected", 32'(motor), 32'd0);
      else chk("grant_order", 32'(motor), 32'(exp_q.pop_front()));
    end
    prev_motor = motor;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    chk("rst_motor", 32'(motor), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", m_cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NC-1:0] seq[$];
    logic          pm;
    int            p2;
    logic          seen_low;
    logic          found;
    for (int c = 0; c < NC; c++) m_pend[c] = 0;
    @(negedge clk);

    // 1: single dose on ch0 from slot 0
    do_reset();
    mask_r = 12'h001;
    step(1'b0, 3'b001, '0, 1'b0);
    chk("t1_motor_t1", 32'(motor), 32'd0);
    idle(1);
    chk("t1_motor_t2", 32'(motor), 32'h1);
    chk("t1_alarm", 32'(alarm), 32'd1);
    idle(24);
    chk("t1_motor_last", 32'(motor), 32'h1);
    idle(1);
    chk("t1_motor_off", 32'(motor), 32'd0);
    idle(10);

    // 2: all channels on slot 1, served 0,1,2,3
    do_reset();
    mask_r = '0;
    for (int c = 0; c < NC; c++) mask_r[c*NS+1] = 1'b1;
    seq.delete();
    step(1'b0, 3'b010, '0, 1'b0);
    for (int i = 0; i < 140; i++) begin
      pm = (motor != '0);
      idle(1);
      if (!pm && motor != '0) seq.push_back(motor);
    end
    chk("t2_pulses", 32'(seq.size()), 32'd4);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      chk("t2_order", 32'(seq[i]), 32'(1 << i));

    // 3: saturation on ch2 during a ch0 pulse
    do_reset();
    mask_r = 12'h001;
    step(1'b0, 3'b001, '0, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 4'b0100, 1'b0);
      idle(1);
    end
    chk("t3_dropped", 32'(dropped), 32'h4);
    p2 = 0;
    for (int i = 0; i < 130; i++) begin
      pm = motor[2];
      idle(1);
      if (motor[2] && !pm) p2++;
    end
    chk("t3_ch2_pulses", 32'(p2), 32'd3);

    // 4: ack on grant cycle keeps alarm, ack one cycle later clears it
    do_reset();
    mask_r = 12'h001;
    step(1'b0, 3'b001, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    chk("t4_alarm_kept", 32'(alarm), 32'd1);
    step(1'b0, '0, '0, 1'b1);
    chk("t4_alarm_clr", 32'(alarm), 32'd0);
    chk("t4_motor_on", 32'(motor), 32'h1);
    idle(35);

    // 5: reset in the middle of a pulse with ch1 holding two doses
    do_reset();
    mask_r = 12'h001;
    step(1'b0, 3'b001, 4'b0010, 1'b0);
    step(1'b0, '0, 4'b0010, 1'b0);
    idle(9);
    step(1'b1, '0, '0, 1'b0);
    chk("t5_motor", 32'(motor), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_alarm", 32'(alarm), 32'd0);
    p2 = 0;
    for (int i = 0; i < 70; i++) begin
      idle(1);
      if (motor != '0) p2++;
    end
    chk("t5_no_pulse", 32'(p2), 32'd0);

    // 6: after ch3 is served, ch0 wins a tie with ch3
    do_reset();
    mask_r = '0;
    step(1'b0, '0, 4'b1000, 1'b0);
    idle(1);
    chk("t6_first", 32'(motor), 32'h8);
    step(1'b0, '0, 4'b1001, 1'b0);
    seen_low = 1'b0; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      idle(1);
      if (motor == '0) seen_low = 1'b1;
      else if (seen_low) found = 1'b1;
    end
    if (!found) chk("t6_timeout", 32'd0, 32'd1);
    else chk("t6_rr_next", 32'(motor), 32'h1);
    idle(40);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [NS-1:0] sp;
      logic [NC-1:0] ov;
      if (i % 200 == 0) mask_r = (NC*NS)'($urandom_range(0, (1 << (NC*NS)) - 1));
      sp = '0; ov = '0;
      for (int s = 0; s < NS; s++) sp[s] = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NC; c++) ov[c] = ($urandom_range(0, 49) == 0);
      step(($urandom_range(0, 799) == 0), sp, ov, ($urandom_range(0, 9) == 0));
    end
    idle(200);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
